// File: rtl/video_timing_pkg.sv
// Shared mode constants, sync bundle type and helpers for the raster timing generator.
package video_timing_pkg;

  localparam int CNT_W = 12;

  // 640x480@60, 25.175 MHz pixel clock, both syncs active-low
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_H_POL    = 1'b0;
  localparam bit VGA_V_POL    = 1'b0;

  // 1280x720@60, 74.25 MHz pixel clock, both syncs active-high
  localparam int HD_H_ACTIVE = 1280;
  localparam int HD_H_FP     = 110;
  localparam int HD_H_SYNC   = 40;
  localparam int HD_H_BP     = 220;
  localparam int HD_V_ACTIVE = 720;
  localparam int HD_V_FP     = 5;
  localparam int HD_V_SYNC   = 5;
  localparam int HD_V_BP     = 20;
  localparam bit HD_H_POL    = 1'b1;
  localparam bit HD_V_POL    = 1'b1;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int HD_H_TOTAL  = HD_H_ACTIVE + HD_H_FP + HD_H_SYNC + HD_H_BP;
  localparam int HD_V_TOTAL  = HD_V_ACTIVE + HD_V_FP + HD_V_SYNC + HD_V_BP;

  // Asserted-true sync/enable bundle; polarity is applied only at the outputs.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 is a wire.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, active/sync decode and the stage-0 register; sync/enable are
// delayed by PIPE so they line up with pixels returned by the pixel source.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = VGA_H_POL,
  parameter bit V_POL    = VGA_V_POL,
  parameter int PIPE     = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             req,
  output logic             sof,
  output logic             sol,
  output logic             hsync,
  output logic             vsync,
  output logic             dena
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if (clog2(H_TOTAL) > CNT_W || clog2(V_TOTAL) > CNT_W || PIPE < 0 || PIPE > 15)
  begin : g_bad_params
    $fatal(1, "video_timing_gen: totals must fit 12-bit counters and PIPE must be 0..15");
  end

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             active;
  sync_t            s0_nxt;
  sync_t            s0;
  sync_t            dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + CNT_W'(1);
    end else begin
      hc <= hc + CNT_W'(1);
    end
  end

  // vc only moves when hc wraps, so the vertical decode naturally switches at hc=0
  always_comb begin
    active    = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
    s0_nxt    = SYNC_IDLE;
    s0_nxt.hs = (int'(hc) >= HS_START) && (int'(hc) < HS_END);
    s0_nxt.vs = (int'(vc) >= VS_START) && (int'(vc) < VS_END);
    s0_nxt.de = active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      req <= 1'b0;
      sof <= 1'b0;
      sol <= 1'b0;
      s0  <= SYNC_IDLE;
    end else begin
      x   <= hc;
      y   <= vc;
      req <= active;
      sof <= (hc == '0) && (vc == '0);
      sol <= (hc == '0);
      s0  <= s0_nxt;
    end
  end

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (s0),
    .dout (dly)
  );

  assign hsync = dly.hs ? H_POL : ~H_POL;
  assign vsync = dly.vs ? V_POL : ~V_POL;
  assign dena  = dly.de;

endmodule

// File: tb/tb_video_timing_gen.sv
// Checks four generator configurations against a position-arithmetic raster model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        req;
    logic        sof;
    logic        sol;
    logic        hsync;
    logic        vsync;
    logic        dena;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = -1;
  bit   started = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // n = raster position index held in S0 (edge R -> 0); -1 while in reset
  always @(posedge clk) begin
    n <= rst ? -1 : n + 1;
    started <= 1'b1;
  end

  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;
  logic a_req, a_sof, a_sol, a_hs, a_vs, a_de;
  logic b_req, b_sof, b_sol, b_hs, b_vs, b_de;
  logic c_req, c_sof, c_sol, c_hs, c_vs, c_de;
  logic d_req, d_sof, d_sol, d_hs, d_vs, d_de;

  // A: small raster 25x15, PIPE=2, active-low syncs
  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .H_POL(1'b0), .V_POL(1'b0), .PIPE(2)) u_a (
    .clk(clk), .rst(rst), .x(a_x), .y(a_y), .req(a_req), .sof(a_sof), .sol(a_sol),
    .hsync(a_hs), .vsync(a_vs), .dena(a_de));

  // B: small raster 16x8, PIPE=0, active-high syncs
  video_timing_gen #(.H_ACTIVE(10), .H_FP(1), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                     .H_POL(1'b1), .V_POL(1'b1), .PIPE(0)) u_b (
    .clk(clk), .rst(rst), .x(b_x), .y(b_y), .req(b_req), .sof(b_sof), .sol(b_sol),
    .hsync(b_hs), .vsync(b_vs), .dena(b_de));

  // C: all defaults (640x480, PIPE=2)
  video_timing_gen u_c (
    .clk(clk), .rst(rst), .x(c_x), .y(c_y), .req(c_req), .sof(c_sof), .sol(c_sol),
    .hsync(c_hs), .vsync(c_vs), .dena(c_de));

  // D: 1280x720 preset, PIPE=3
  video_timing_gen #(.H_ACTIVE(HD_H_ACTIVE), .H_FP(HD_H_FP), .H_SYNC(HD_H_SYNC), .H_BP(HD_H_BP),
                     .V_ACTIVE(HD_V_ACTIVE), .V_FP(HD_V_FP), .V_SYNC(HD_V_SYNC), .V_BP(HD_V_BP),
                     .H_POL(HD_H_POL), .V_POL(HD_V_POL), .PIPE(3)) u_d (
    .clk(clk), .rst(rst), .x(d_x), .y(d_y), .req(d_req), .sof(d_sof), .sol(d_sol),
    .hsync(d_hs), .vsync(d_vs), .dena(d_de));

  function automatic obs_t model(input int idx, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp, input int pipe, input bit hpol, input bit vpol);
    obs_t e;
    int ht, vt, p, q, qx, qy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    e = '0;
    e.hsync = ~hpol;
    e.vsync = ~vpol;
    if (idx >= 0) begin
      p = idx % (ht * vt);
      e.x   = 12'(p % ht);
      e.y   = 12'(p / ht);
      e.req = ((p % ht) < ha) && ((p / ht) < va);
      e.sof = (p == 0);
      e.sol = ((p % ht) == 0);
      if (idx - pipe >= 0) begin
        q  = (idx - pipe) % (ht * vt);
        qx = q % ht;
        qy = q / ht;
        e.hsync = (qx >= ha + hfp && qx < ha + hfp + hsw) ? hpol : ~hpol;
        e.vsync = (qy >= va + vfp && qy < va + vfp + vsw) ? vpol : ~vpol;
        e.dena  = (qx < ha) && (qy < va);
      end
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s n=%0d actual x=%0d y=%0d req=%b sof=%b sol=%b hs=%b vs=%b de=%b required x=%0d y=%0d req=%b sof=%b sol=%b hs=%b vs=%b de=%b",
               nm, n, act.x, act.y, act.req, act.sof, act.sol, act.hsync, act.vsync, act.dena,
               exp.x, exp.y, exp.req, exp.sof, exp.sol, exp.hsync, exp.vsync, exp.dena);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s n=%0d actual=%0d required=%0d", nm, n, act, exp);
    end
  endtask

  int last_sof = -1;
  int req_cnt = 0;
  int vs_run = 0;
  int hs_run = 0;

  always @(negedge clk) begin
    if (started) begin
      cmp("a_cycle", {a_x, a_y, a_req, a_sof, a_sol, a_hs, a_vs, a_de},
          model(n, 16, 2, 4, 3, 8, 2, 2, 3, 2, 1'b0, 1'b0));
      cmp("b_cycle", {b_x, b_y, b_req, b_sof, b_sol, b_hs, b_vs, b_de},
          model(n, 10, 1, 3, 2, 4, 1, 1, 2, 0, 1'b1, 1'b1));
      cmp("c_cycle", {c_x, c_y, c_req, c_sof, c_sol, c_hs, c_vs, c_de},
          model(n, VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP, 2, VGA_H_POL, VGA_V_POL));
      cmp("d_cycle", {d_x, d_y, d_req, d_sof, d_sol, d_hs, d_vs, d_de},
          model(n, HD_H_ACTIVE, HD_H_FP, HD_H_SYNC, HD_H_BP,
                HD_V_ACTIVE, HD_V_FP, HD_V_SYNC, HD_V_BP, 3, HD_H_POL, HD_V_POL));

      // hand-computed anchors for the model itself
      case (n)
        -1: begin
          lit("rst_a_hsync", int'(a_hs), 1);
          lit("rst_b_hsync", int'(b_hs), 0);
          lit("rst_c_req_sof", int'({c_req, c_sof, c_de}), 0);
        end
        0: begin
          lit("r_a_xy", int'({a_x, a_y}), 0);
          lit("r_a_req_sof_sol", int'({a_req, a_sof, a_sol}), 7);
          lit("r_a_hs_vs_de", int'({a_hs, a_vs, a_de}), 6);
          lit("r_c_req_sof", int'({c_req, c_sof}), 3);
        end
        1:    lit("r1_a_dena", int'(a_de), 0);
        2: begin
          lit("r2_a_dena", int'(a_de), 1);
          lit("r2_c_dena", int'(c_de), 1);
        end
        10:   lit("b_hsync_x10", int'(b_hs), 0);
        11:   lit("b_hsync_x11", int'(b_hs), 1);
        14:   lit("b_hsync_x14", int'(b_hs), 0);
        19:   lit("a_hsync_n19", int'(a_hs), 1);
        20:   lit("a_hsync_n20", int'(a_hs), 0);
        24:   lit("a_hsync_n24", int'(a_hs), 1);
        251:  lit("a_vsync_n251", int'(a_vs), 1);
        252:  lit("a_vsync_n252", int'(a_vs), 0);
        657:  lit("c_hsync_n657", int'(c_hs), 1);
        658:  lit("c_hsync_n658", int'(c_hs), 0);
        753:  lit("c_hsync_n753", int'(c_hs), 0);
        754:  lit("c_hsync_n754", int'(c_hs), 1);
        1649: lit("d_x_last", int'(d_x), 1649);
        1650: begin
          lit("d_x_wrap", int'(d_x), 0);
          lit("d_y_inc", int'(d_y), 1);
        end
        default: ;
      endcase

      // frame-level properties of raster A (375 clocks, 16x8 active, 50-clock vsync, 4-clock hsync)
      if (n < 0) begin
        last_sof = -1;
        req_cnt  = 0;
        vs_run   = 0;
        hs_run   = 0;
      end else begin
        if (a_sof) begin
          if (last_sof >= 0) begin
            lit("a_frame_len", n - last_sof, 375);
            lit("a_req_per_frame", req_cnt, 128);
          end
          last_sof = n;
          req_cnt  = 0;
        end
        if (a_req) req_cnt++;
        if (!a_vs) vs_run++;
        else if (vs_run > 0) begin
          lit("a_vsync_low_len", vs_run, 50);
          vs_run = 0;
        end
        if (!a_hs) hs_run++;
        else if (hs_run > 0) begin
          lit("a_hsync_low_len", hs_run, 4);
          hs_run = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // two full A frames, then reset while A's S0 is at (x=10, y=5)
    for (int i = 0; i < 3000 && n != 885; i++) @(negedge clk);
    lit("reach_midframe", n, 885);
    lit("a_mid_xy", int'({a_x, a_y}), int'({12'd10, 12'd5}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
